// File: rtl/pp_gen_pipe.sv
// rtl/pp_gen_pipe.sv - two-stage partial-product generator for a 12x12 multiplier
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake; in_a, in_b two's complement, in_tag sideband
//   out_valid/out_ready        result handshake to the compressor/adder stage
//   out_pp                     12 rows x 12 bits, row i = out_pp[12*i +: 12], bit j weight 2^(i+j)
//   out_tag, out_zero          passed-through tag, flag for a zero operand
//   busy                       any stage holds a valid entry
module pp_gen_pipe #(
    parameter int TAG_W  = 4,
    parameter bit BW_INV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_a,
    input  logic [11:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [143:0]     out_pp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             busy
);
    localparam int N = 12;

    logic             s1_v;
    logic [N-1:0]     s1_a;
    logic [N-1:0]     s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_v;
    logic [N*N-1:0]   s2_pp;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_zero;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic [N*N-1:0]   pp_next;
    logic             zero_next;

    assign s2_free  = !s2_v || out_ready;
    assign s1_adv   = s1_v && s2_free;
    // Held high through reset so the upstream never sees a stall; anything
    // offered while rst is high is simply not captured.
    assign in_ready = rst || !s1_v || s2_free;
    assign in_fire  = in_valid && in_ready;

    // Baugh-Wooley: the sign row and sign column are complemented except the
    // corner bit; the correction constants are added downstream.
    always_comb begin
        pp_next = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp_next[N*i+j] = s1_a[j] & s1_b[i];
                if (BW_INV && ((i == N-1) != (j == N-1))) begin
                    pp_next[N*i+j] = ~(s1_a[j] & s1_b[i]);
                end
            end
        end
    end

    assign zero_next = (s1_a == '0) || (s1_b == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
        end else begin
            if (in_fire) begin
                s1_v   <= 1'b1;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_pp   <= '0;
            s2_tag  <= '0;
            s2_zero <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_v    <= 1'b1;
                s2_pp   <= pp_next;
                s2_tag  <= s1_tag;
                s2_zero <= zero_next;
            end else if (out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_pp    = s2_pp;
    assign out_tag   = s2_tag;
    assign out_zero  = s2_zero;
    assign busy      = s1_v || s2_v;
endmodule

// File: tb/tb_pp_gen_pipe.sv
// tb/tb_pp_gen_pipe.sv - scoreboard bench for pp_gen_pipe
module tb_pp_gen_pipe;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [11:0]  in_a;
    logic [11:0]  in_b;
    logic [3:0]   in_tag;
    logic         out_ready;
    logic         in_ready,  in_ready0;
    logic         out_valid, out_valid0;
    logic [143:0] out_pp,    out_pp0;
    logic [3:0]   out_tag,   out_tag0;
    logic         out_zero,  out_zero0;
    logic         busy,      busy0;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_del = 0;
    int rdy_mode = 0;  // 0 always ready, 1 never, 2 toggle, 3 random

    typedef struct {
        logic [3:0]  tag;
        logic        zero;
        logic [23:0] sp;
        logic [23:0] up;
    } exp_t;
    exp_t sb[$];

    logic         prev_stall = 1'b0;
    logic [143:0] prev_pp;
    logic [3:0]   prev_tag;

    always #5 clk = ~clk;

    pp_gen_pipe #(.TAG_W(4), .BW_INV(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp),
        .out_tag(out_tag), .out_zero(out_zero), .busy(busy)
    );

    pp_gen_pipe #(.TAG_W(4), .BW_INV(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pp(out_pp0),
        .out_tag(out_tag0), .out_zero(out_zero0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] row_sum(input logic [143:0] pp, input bit bw);
        logic [23:0] s = '0;
        for (int i = 0; i < 12; i++) s = s + ({12'b0, pp[12*i +: 12]} << i);
        if (bw) s = s + 24'h001000 + 24'h800000;
        return s;
    endfunction

    function automatic exp_t make_exp(input logic [11:0] a, input logic [11:0] b, input logic [3:0] t);
        exp_t e;
        logic signed [23:0] sa, sb2;
        sa = {{12{a[11]}}, a};
        sb2 = {{12{b[11]}}, b};
        e.tag  = t;
        e.zero = (a == 12'd0) || (b == 12'd0);
        e.sp   = 24'(sa * sb2);
        e.up   = {12'b0, a} * {12'b0, b};
        return e;
    endfunction

    // out_ready pattern, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: push on accept, pop and compare on delivery, check hold on stall
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_pp", out_pp, prev_pp);
                chk("stall_tag", {140'b0, out_tag}, {140'b0, prev_tag});
                chk("stall_valid", {143'b0, out_valid}, 144'd1);
            end
            if (in_valid && in_ready) begin
                sb.push_back(make_exp(in_a, in_b, in_tag));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_del++;
                if (sb.size() == 0) begin
                    chk("spurious_out", 144'd1, 144'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_tag", {140'b0, out_tag}, {140'b0, e.tag});
                    chk("out_zero", {143'b0, out_zero}, {143'b0, e.zero});
                    chk("signed_prod", {120'b0, row_sum(out_pp, 1'b1)}, {120'b0, e.sp});
                    chk("valid_bw0", {143'b0, out_valid0}, 144'd1);
                    chk("unsigned_prod", {120'b0, row_sum(out_pp0, 1'b0)}, {120'b0, e.up});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_pp    = out_pp;
            prev_tag   = out_tag;
        end
    end

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [3:0] t);
        logic ok;
        int   cyc = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 200);
        if (!ok) chk("send_timeout", 144'd1, 144'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        chk("drain_timeout", {143'b0, (cyc >= 500)}, 144'd0);
        @(negedge clk);
    endtask

    function automatic logic [143:0] rows(input logic [11:0] r0, input logic [11:0] mid, input logic [11:0] r11);
        logic [143:0] v;
        v[11:0] = r0;
        for (int i = 1; i < 11; i++) v[12*i +: 12] = mid;
        v[143:132] = r11;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {143'b0, in_ready}, 144'd1);
        chk("rst_out_valid", {143'b0, out_valid}, 144'd0);
        chk("rst_busy", {143'b0, busy}, 144'd0);
        chk("rst_out_pp", out_pp, 144'd0);
        chk("rst_tag_zero", {139'b0, out_tag, out_zero}, 144'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency and row pattern for 0x7FF * 1
        in_valid = 1'b1; in_a = 12'h7FF; in_b = 12'h001; in_tag = 4'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", {143'b0, out_valid}, 144'd0);
        @(negedge clk);
        chk("lat_cycle2", {143'b0, out_valid}, 144'd1);
        chk("d1_rows", out_pp, rows(12'hFFF, 12'h800, 12'h7FF));
        chk("d1_tag", {140'b0, out_tag}, 144'd5);
        chk("d1_zero", {143'b0, out_zero}, 144'd0);
        drain();

        // Zero multiplicand, sign-only multiplier
        in_valid = 1'b1; in_a = 12'h000; in_b = 12'h800; in_tag = 4'd6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("d2_rows", out_pp, rows(12'h800, 12'h800, 12'h7FF));
        chk("d2_zero", {143'b0, out_zero}, 144'd1);
        chk("d2_rows_bw0", out_pp0, 144'd0);
        drain();

        // Backpressure: two accepts fill the pipe, third waits
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send(12'h123, 12'h456, 4'd1);
        send(12'hABC, 12'h00F, 4'd2);
        @(negedge clk);
        chk("bp_in_ready", {143'b0, in_ready}, 144'd0);
        chk("bp_hold_tag", {140'b0, out_tag}, 144'd1);
        chk("bp_busy", {143'b0, busy}, 144'd1);
        rdy_mode = 0;
        send(12'hFFF, 12'hFFF, 4'd3);
        drain();

        // Alternating out_ready under continuous input
        rdy_mode = 2;
        for (int k = 0; k < 12; k++) send(12'($urandom), 12'($urandom), 4'(k));
        rdy_mode = 0;
        drain();

        // Reset with both stages full, plus an input offered during reset
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send(12'h055, 12'h0AA, 4'd9);
        send(12'h066, 12'h011, 4'd10);
        @(negedge clk);
        chk("pre_rst_busy", {143'b0, busy}, 144'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b1; in_a = 12'h321; in_b = 12'h111; in_tag = 4'hE;
        @(negedge clk);
        chk("rst_mid_in_ready", {143'b0, in_ready}, 144'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {143'b0, out_valid}, 144'd0);
        chk("post_rst_busy", {143'b0, busy}, 144'd0);
        chk("post_rst_pp", out_pp, 144'd0);
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        chk("no_stale_out", {143'b0, out_valid}, 144'd0);
        n_acc = 0;
        n_del = 0;
        send(12'h801, 12'h7FF, 4'd7);
        drain();

        // Random traffic with random gaps and random backpressure
        rdy_mode = 3;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
            send(12'($urandom), 12'($urandom), 4'(k));
        end
        send(12'h800, 12'h800, 4'd0);
        send(12'hFFF, 12'h800, 4'd1);
        send(12'h000, 12'h000, 4'd2);
        rdy_mode = 0;
        drain();
        chk("sb_empty", {112'b0, 32'(sb.size())}, 144'd0);
        chk("acc_eq_del", {112'b0, 32'(n_del)}, {112'b0, 32'(n_acc)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pp_gen_pipe.md
PP_GEN_PIPE -- requirements
Module: pp_gen_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operand pair.
REQ-002 SHALL have parameter BW_INV, default 1: 1 = Baugh-Wooley signed partial products; 0 = plain unsigned AND array.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair present.
REQ-006 SHALL have port in_ready, output, 1: block accepts the operand pair this cycle.
REQ-007 SHALL have port in_a, input, 12: multiplicand, two's complement.
REQ-008 SHALL have port in_b, input, 12: multiplier, two's complement.
REQ-009 SHALL have port in_tag, input, TAG_W: sideband, passed through unchanged.
REQ-010 SHALL have port out_valid, output, 1: out_pp, out_tag and out_zero are valid.
REQ-011 SHALL have port out_ready, input, 1: the downstream compressor/adder stage accepts the output.
REQ-012 SHALL have port out_pp, output, 144: 12 rows x 12 bits; row i = out_pp[12*i +: 12], bit j of row i has weight 2^(i+j).
REQ-013 SHALL have port out_tag, output, TAG_W: tag of the output transaction.
REQ-014 SHALL have port out_zero, output, 1: in_a == 0 or in_b == 0 for the output transaction.
REQ-015 SHALL have port busy, output, 1: at least one pipeline stage holds a valid entry.

Function
REQ-016 SHALL be a two-stage pipeline: S1 registers {a, b, tag}; S2 registers {pp, tag, zero}. Each stage has its own valid bit, s1_v and s2_v.
REQ-017 A transfer SHALL occur on an interface when valid && ready are both high at a rising edge.
REQ-018 s2_free SHALL equal !s2_v || out_ready.
REQ-019 in_ready SHALL equal !s1_v || s2_free. This is combinational; no registered-ready bubble is allowed.
REQ-020 S1 SHALL advance into S2 when s1_v && s2_free.
REQ-021 When S1 advances and a new input transfer occurs in the same cycle, S1 SHALL load the new operands.
REQ-022 When S1 advances and no new input transfer occurs, s1_v SHALL clear.
REQ-023 When S2 is consumed and S1 is empty, s2_v SHALL clear.
REQ-024 S2 contents SHALL remain stable while out_valid && !out_ready; this holds for out_pp, out_tag and out_zero.
REQ-025 Latency from input transfer to out_valid SHALL be 2 cycles with out_ready held high.
REQ-026 Throughput SHALL be one transaction per cycle with out_ready held high.
REQ-027 Transactions SHALL never be dropped, duplicated or reordered.
REQ-028 Partial product bit pp[i][j] SHALL equal a[j] & b[i]. With BW_INV = 1, the bit SHALL be inverted when exactly one of i, j equals 11.
REQ-029 The block SHALL NOT add the Baugh-Wooley correction constants 2^12 and 2^23. The downstream compressor owns them.
REQ-030 out_pp SHALL be driven directly from S2 registers, with no combinational logic after the flops.
REQ-031 out_zero SHALL be computed in S1 to S2 from the S1 operands.
REQ-032 busy SHALL equal s1_v || s2_v.

Reset
REQ-033 While rst is high at a rising edge: s1_v = 0, s2_v = 0, out_valid = 0, busy = 0.
REQ-034 While rst is high at a rising edge: out_pp = 0, out_tag = 0, out_zero = 0, and the S1 data registers = 0.
REQ-035 in_ready SHALL be 1 during and after reset. Any input transfer coincident with rst SHALL be discarded.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight transactions. The first out_valid after reset SHALL come only from an input transferred after rst deasserts.

Verification
REQ-037 Directed: a = 0x7FF, b = 0x001, tag = 5, out_ready = 1. Required: out_valid exactly 2 cycles later; row 0 = 0xFFF; rows 1..10 = 0x800; row 11 = 0x7FF; out_tag = 5; out_zero = 0.
REQ-038 Directed: a = 0x000, b = 0x800. Required: rows 0..10 = 0x800, row 11 = 0x7FF, out_zero = 1. With BW_INV = 0, all rows = 0x000.
REQ-039 Directed: 3 back-to-back inputs with out_ready = 0. Required: outputs hold first entry; in_ready drops after 2 accepts; release yields tags in order, one per cycle, no loss.
REQ-040 Directed: out_ready toggles 1,0,1,0 under continuous in_valid. Required: out_pp is stable during each stall cycle; the transaction count accepted equals the count delivered.
REQ-041 Directed: assert rst for 1 cycle while s1_v = s2_v = 1. Required: next cycle out_valid = 0 and busy = 0; no stale tag appears afterwards.
REQ-042 Random: 10k operand pairs fed through pp_gen_pipe, then the compressor, then the final adder, with the compressor's approximate columns replaced by the exact reference model. Required: product equals signed a*b mod 2^24.
